// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART responder: register offsets, STATUS bit
// positions, shifter state encoding and oversampling constants.
package mmio_uart_pkg;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);

    // Register offsets
    localparam logic [ADDR_W-1:0] UART_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] UART_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] UART_DIV_LO = 3'd2;
    localparam logic [ADDR_W-1:0] UART_DIV_HI = 3'd3;
    localparam logic [ADDR_W-1:0] UART_CTRL   = 3'd4;
    localparam logic [ADDR_W-1:0] UART_RX_CNT = 3'd5;
    localparam logic [ADDR_W-1:0] UART_TX_CNT = 3'd6;

    // STATUS bit positions
    localparam int unsigned ST_RX_AVAIL  = 0;
    localparam int unsigned ST_RX_FULL   = 1;
    localparam int unsigned ST_TX_EMPTY  = 2;
    localparam int unsigned ST_TX_FULL   = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_FRAME_ERR = 5;
    localparam int unsigned ST_TX_OVF    = 6;
    localparam int unsigned ST_RX_OVF    = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head. A push into a full FIFO is only
// accepted when a pop happens in the same clk; a pop from an empty FIFO is ignored.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO UART responder: register file, TX/RX FIFOs, baud tick generator and
// 8N1 serial shifters. Optional internal loopback under UART_LOOPBACK_EN.
module mmio_uart_responder
    import mmio_uart_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 16,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = 16'd53
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_wen,
    input  logic              rx_ren,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_din,
    output logic [DATA_W-1:0] uart_dout,
    input  logic              uart_rx_i,
    output logic              uart_tx_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    // Configuration and sticky status
    logic [7:0]       div_lo, div_hi;
    logic             tx_en, rx_en, loopback;
    logic             rx_ovf, tx_ovf, frame_err;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    // FIFO interfaces
    logic             tx_push, tx_pop_c, tx_full, tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic [7:0]       tx_head;
    logic             rx_pop, rx_push_c, rx_full, rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic [7:0]       rx_head;

    // Shifters
    uart_state_e      tx_state, rx_state;
    logic [OS_W-1:0]  tx_os, rx_os;
    logic [2:0]       tx_bit, rx_bit;
    logic [7:0]       tx_shift, rx_shift;
    logic             tx_line;
    logic             rx_src, rx_meta, rx_sync, rx_prev;
    logic             rx_stop_c;

    logic             div_wr;
    logic [2:0]       st_clr;
    logic [7:0]       status;

    assign tx_push  = tx_wen & (uart_addr == UART_DATA);
    assign rx_pop   = rx_ren & (uart_addr == UART_DATA);
    assign tx_pop_c = (tx_state == IDLE) & tx_en & ~tx_empty;
    assign div_wr   = tx_wen & ((uart_addr == UART_DIV_LO) | (uart_addr == UART_DIV_HI));
    assign st_clr   = (tx_wen && uart_addr == UART_STATUS) ? uart_din[7:5] : 3'b000;
    assign tick     = (tick_cnt == {div_hi, div_lo});

    assign rx_stop_c = (rx_state == STOP) & tick & (rx_os == OS_LAST);
    assign rx_push_c = rx_stop_c & rx_sync;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop_c),
        .din   (uart_din),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_c),
        .pop   (rx_pop),
        .din   (rx_shift),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    // Divisor and enable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_lo <= DEFAULT_DIV[7:0];
            div_hi <= DEFAULT_DIV[15:8];
            tx_en  <= 1'b1;
            rx_en  <= 1'b1;
        end else if (tx_wen) begin
            case (uart_addr)
                UART_DIV_LO: div_lo <= uart_din;
                UART_DIV_HI: div_hi <= uart_din;
                UART_CTRL: begin
                    tx_en <= uart_din[0];
                    rx_en <= uart_din[1];
                end
                default: ;
            endcase
        end
    end

`ifdef UART_LOOPBACK_EN
    // Loopback control bit
    always_ff @(posedge clk) begin
        if (rst) loopback <= 1'b0;
        else if (tx_wen && uart_addr == UART_CTRL) loopback <= uart_din[2];
    end
    assign rx_src = loopback ? tx_line : uart_rx_i;
`else
    assign loopback = 1'b0;
    assign rx_src   = uart_rx_i;
`endif

    // Sticky error flags; a set in the same clk as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_ovf    <= (rx_ovf & ~st_clr[2]) | (rx_push_c & rx_full & ~rx_pop);
            tx_ovf    <= (tx_ovf & ~st_clr[1]) | (tx_push & tx_full & ~tx_pop_c);
            frame_err <= (frame_err & ~st_clr[0]) | (rx_stop_c & ~rx_sync);
        end
    end

    // Oversample tick: counts 0..DIV, restarted by any divisor write
    always_ff @(posedge clk) begin
        if (rst || div_wr) tick_cnt <= '0;
        else if (tick)     tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + DIV_W'(1);
    end

    // TX shifter: start, 8 data bits LSB first, stop; 16 ticks per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_line <= 1'b1;
                    if (tx_pop_c) begin
                        tx_shift <= tx_head;
                        tx_os    <= '0;
                        tx_line  <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: if (tick) begin
                    if (tx_os == OS_LAST) begin
                        tx_os    <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_os <= tx_os + OS_W'(1);
                    end
                end
                DATA: if (tick) begin
                    if (tx_os == OS_LAST) begin
                        tx_os <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_os <= tx_os + OS_W'(1);
                    end
                end
                STOP: if (tick) begin
                    if (tx_os == OS_LAST) begin
                        tx_os    <= '0;
                        tx_state <= IDLE;
                    end else begin
                        tx_os <= tx_os + OS_W'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Serial output register; held idle while looped back
    always_ff @(posedge clk) begin
        if (rst) uart_tx_o <= 1'b1;
        else     uart_tx_o <= tx_line | loopback;
    end

    // Two-stage synchroniser plus edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX shifter: mid-start qualify, mid-bit data samples, stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                IDLE: if (rx_en && rx_prev && !rx_sync) begin
                    rx_os    <= '0;
                    rx_state <= START;
                end
                START: if (tick) begin
                    if (rx_os == OS_HALF) begin
                        rx_os    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        rx_os <= rx_os + OS_W'(1);
                    end
                end
                DATA: if (tick) begin
                    if (rx_os == OS_LAST) begin
                        rx_os    <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_os <= rx_os + OS_W'(1);
                    end
                end
                STOP: if (tick) begin
                    if (rx_os == OS_LAST) begin
                        rx_os    <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_os <= rx_os + OS_W'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // STATUS assembly
    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_BUSY]   = (tx_state != IDLE);
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_RX_OVF]    = rx_ovf;
    end

    // Combinational read mux
    always_comb begin
        uart_dout = '0;
        case (uart_addr)
            UART_DATA:   uart_dout = rx_empty ? 8'h00 : rx_head;
            UART_STATUS: uart_dout = status;
            UART_DIV_LO: uart_dout = div_lo;
            UART_DIV_HI: uart_dout = div_hi;
            UART_CTRL:   uart_dout = {5'b0, loopback, rx_en, tx_en};
            UART_RX_CNT: uart_dout = 8'(rx_count);
            UART_TX_CNT: uart_dout = 8'(tx_count);
            default:     uart_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed bench for mmio_uart_responder. Optional loopback path checked when
// UART_LOOPBACK_EN is defined.
module tb_mmio_uart_responder;

    logic       clk;
    logic       rst;
    logic       tx_wen;
    logic       rx_ren;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       uart_rx_i;
    logic       uart_tx_o;

    int         tests;
    int         fails;
    logic [7:0] rd;
    logic [7:0] pat;
    logic       found;
    int         lows;

    mmio_uart_responder dut (
        .clk       (clk),
        .rst       (rst),
        .tx_wen    (tx_wen),
        .rx_ren    (rx_ren),
        .uart_addr (uart_addr),
        .uart_din  (uart_din),
        .uart_dout (uart_dout),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        uart_addr = a;
        uart_din  = d;
        tx_wen    = 1'b1;
        @(negedge clk);
        tx_wen    = 1'b0;
    endtask

    task automatic rdreg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        uart_addr = a;
        rx_ren    = 1'b1;
        #1 d = uart_dout;
        @(negedge clk);
        rx_ren    = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx_i = stop;
        repeat (16) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_tx_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        tx_wen    = 1'b0;
        rx_ren    = 1'b0;
        uart_addr = '0;
        uart_din  = '0;
        uart_rx_i = 1'b1;
        tests     = 0;
        fails     = 0;

        // Reset state
        do_reset();
        rdreg(3'd1, rd); check("reset_status", rd, 8'h04);  // only tx_empty
        rdreg(3'd2, rd); check("reset_div_lo", rd, 8'h35);
        rdreg(3'd3, rd); check("reset_div_hi", rd, 8'h00);
        rdreg(3'd4, rd); check("reset_ctrl", rd, 8'h03);
        rdreg(3'd5, rd); check("reset_rx_cnt", rd, 8'h00);
        rdreg(3'd7, rd); check("offset7_read", rd, 8'h00);
        check("reset_tx_line", {7'b0, uart_tx_o}, 8'h01);

        // TX frame 0xA5 at DIV=0
        wr(3'd2, 8'h00);
        rdreg(3'd2, rd); check("div_lo_wr", rd, 8'h00);
        pat = 8'hA5;
        wr(3'd0, pat);
        wait_tx_low(found);
        check("tx_start_seen", {7'b0, found}, 8'h01);
        rdreg(3'd1, rd); check("tx_busy_status", rd, 8'h14);
        repeat (6) @(negedge clk);
        check("tx_start_bit", {7'b0, uart_tx_o}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            check($sformatf("tx_bit%0d", i), {7'b0, uart_tx_o}, {7'b0, pat[i]});
        end
        repeat (16) @(negedge clk);
        check("tx_stop_bit", {7'b0, uart_tx_o}, 8'h01);
        repeat (16) @(negedge clk);
        rdreg(3'd1, rd); check("tx_idle_status", rd, 8'h04);

        // RX frame 0x3C at DIV=0
        send_rx(8'h3C, 1'b1);
        rdreg(3'd5, rd); check("rx_cnt_one", rd, 8'h01);
        rdreg(3'd1, rd); check("rx_avail_status", rd, 8'h05);
        rdreg(3'd0, rd); check("rx_data", rd, 8'h3C);
        rdreg(3'd5, rd); check("rx_cnt_zero", rd, 8'h00);
        rdreg(3'd0, rd); check("rx_empty_read", rd, 8'h00);

        // TX overflow with transmitter disabled
        do_reset();
        wr(3'd4, 8'h02);
        for (int i = 0; i < 17; i++) wr(3'd0, 8'(i));
        rdreg(3'd6, rd); check("tx_cnt_full", rd, 8'h10);
        rdreg(3'd1, rd); check("tx_ovf_status", rd, 8'h48);
        wr(3'd1, 8'h40);
        rdreg(3'd1, rd); check("tx_ovf_clear", rd, 8'h08);
        check("tx_line_idle_disabled", {7'b0, uart_tx_o}, 8'h01);

        // Framing error, then a short glitch, then a clean frame
        do_reset();
        wr(3'd2, 8'h00);
        send_rx(8'h55, 1'b0);
        rdreg(3'd5, rd); check("ferr_rx_cnt", rd, 8'h00);
        rdreg(3'd1, rd); check("ferr_status", rd, 8'h24);
        wr(3'd1, 8'h20);
        rdreg(3'd1, rd); check("ferr_clear", rd, 8'h04);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (40) @(negedge clk);
        rdreg(3'd5, rd); check("glitch_rx_cnt", rd, 8'h00);
        rdreg(3'd1, rd); check("glitch_status", rd, 8'h04);
        send_rx(8'h81, 1'b1);
        rdreg(3'd0, rd); check("post_glitch_data", rd, 8'h81);

        // Loopback control
        do_reset();
        wr(3'd2, 8'h00);
        wr(3'd4, 8'h07);
`ifdef UART_LOOPBACK_EN
        rdreg(3'd4, rd); check("ctrl_loopback", rd, 8'h07);
        wr(3'd0, 8'h5A);
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) lows++;
        end
        check("loop_tx_held", 8'(lows), 8'h00);
        rdreg(3'd5, rd); check("loop_rx_cnt", rd, 8'h01);
        rdreg(3'd0, rd); check("loop_rx_data", rd, 8'h5A);
`else
        rdreg(3'd4, rd); check("ctrl_no_loopback", rd, 8'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
